fm_demod_counter: RTL and testbench

- Receive-side counterpart to the NCO-based FM sine generator.
- Takes digitised FM sine samples (ADC or loopback of the DAC code) and measures carrier frequency by counting hysteretic rising mid-level crossings over a fixed gate window.
- Converts the crossing count back to a distance code with a linear scale, clamp and range flag.
- Sits between the sample source and the distance display/compare logic.

---
 rtl/fm_demod_counter.sv | 179 +++++++++++++++++
 tb/tb_fm_demod_counter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fm_demod_counter.sv
// FM carrier frequency demodulator: counts hysteretic rising mid-level crossings
// over a gate window of enabled samples and maps the count to a distance code.
module fm_demod_counter #(
  parameter int SINE_WIDTH    = 8,
  parameter int WIDTH         = 13,
  parameter int COUNT_WIDTH   = 16,
  parameter int WINDOW_CYCLES = 50000,
  parameter int MID_LEVEL     = 128,
  parameter int HYST          = 16,
  parameter int CNT_MIN       = 9000,
  parameter int CNT_MAX       = 11000,
  parameter int DIST_NUM      = 1,
  parameter int DIST_SHIFT    = 0,
  parameter int MAX_DIST      = 2000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [SINE_WIDTH-1:0]  sample,
  output logic [COUNT_WIDTH-1:0] freq_count,
  output logic [WIDTH-1:0]       distance,
  output logic                   dist_valid,
  output logic                   out_of_range,
  output logic                   locked
);

  localparam int SMAX   = (1 << SINE_WIDTH) - 1;
  localparam int HI_RAW = MID_LEVEL + HYST;
  localparam int LO_RAW = MID_LEVEL - HYST;
  localparam int HI_SAT = (HI_RAW > SMAX) ? SMAX : ((HI_RAW < 0) ? 0 : HI_RAW);
  localparam int LO_SAT = (LO_RAW < 0) ? 0 : ((LO_RAW > SMAX) ? SMAX : LO_RAW);

  localparam logic [SINE_WIDTH-1:0] HI_TH = SINE_WIDTH'(HI_SAT);
  localparam logic [SINE_WIDTH-1:0] LO_TH = SINE_WIDTH'(LO_SAT);

  localparam int GATE_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(WINDOW_CYCLES - 1);

  localparam logic [COUNT_WIDTH-1:0] CMIN = COUNT_WIDTH'(CNT_MIN);
  localparam logic [COUNT_WIDTH-1:0] CMAX = COUNT_WIDTH'(CNT_MAX);

  localparam int PW    = COUNT_WIDTH + 16;
  localparam int WMAXI = (1 << WIDTH) - 1;
  localparam int LIM   = (MAX_DIST < WMAXI) ? MAX_DIST : WMAXI;
  localparam logic [15:0]   DNUM  = 16'(DIST_NUM);
  localparam logic [PW-1:0] LIM_P = PW'(LIM);

  typedef enum logic { DET_LOW, DET_HIGH } det_t;
  typedef enum logic { WARMUP, RUN } fsm_t;

  det_t det_q, det_d;
  fsm_t state_q, state_d;

  logic                   crossing;
  logic                   win_close;
  logic                   launch;
  logic [GATE_W-1:0]      gate_q;
  logic [COUNT_WIDTH-1:0] cross_cnt;
  logic [COUNT_WIDTH-1:0] cross_inc;
  logic [COUNT_WIDTH-1:0] cnt_now;

  logic                   cap_valid;
  logic [COUNT_WIDTH-1:0] cap_cnt;
  logic                   s1_valid;
  logic                   s1_oor;
  logic [COUNT_WIDTH-1:0] s1_diff;

  logic [PW-1:0] prod;
  logic [PW-1:0] scaled;
  logic [PW-1:0] clamped;

  // Crossing detector
  always_comb begin
    det_d    = det_q;
    crossing = 1'b0;
    if (enable) begin
      case (det_q)
        DET_LOW: begin
          if (sample >= HI_TH) begin
            det_d    = DET_HIGH;
            crossing = 1'b1;
          end
        end
        DET_HIGH: begin
          if (sample <= LO_TH) begin
            det_d = DET_LOW;
          end
        end
        default: det_d = DET_LOW;
      endcase
    end
  end

  // Count as seen on this cycle, so a crossing on the closing cycle is included
  assign win_close = enable && (gate_q == GATE_LAST);
  assign cross_inc = (cross_cnt == '1) ? cross_cnt : cross_cnt + COUNT_WIDTH'(1);
  assign cnt_now   = crossing ? cross_inc : cross_cnt;

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      WARMUP: begin
        if (win_close) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (win_close) begin
          launch = 1'b1;
        end
      end
      default: state_d = WARMUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      det_q     <= DET_LOW;
      state_q   <= WARMUP;
      gate_q    <= '0;
      cross_cnt <= '0;
    end else begin
      det_q   <= det_d;
      state_q <= state_d;
      if (enable) begin
        if (win_close) begin
          gate_q    <= '0;
          cross_cnt <= '0;
        end else begin
          gate_q    <= gate_q + GATE_W'(1);
          cross_cnt <= cnt_now;
        end
      end
    end
  end

  // Scale stage: diff * DIST_NUM >> DIST_SHIFT, clamped to the distance ceiling
  always_comb begin
    prod    = PW'(s1_diff) * PW'(DNUM);
    scaled  = prod >> DIST_SHIFT;
    clamped = (scaled > LIM_P) ? LIM_P : scaled;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_valid    <= 1'b0;
      cap_cnt      <= '0;
      s1_valid     <= 1'b0;
      s1_oor       <= 1'b0;
      s1_diff      <= '0;
      freq_count   <= '0;
      distance     <= '0;
      dist_valid   <= 1'b0;
      out_of_range <= 1'b0;
      locked       <= 1'b0;
    end else begin
      cap_valid <= launch;
      if (launch) begin
        cap_cnt <= cnt_now;
      end

      s1_valid <= cap_valid;
      if (cap_valid) begin
        freq_count <= cap_cnt;
        s1_diff    <= (cap_cnt >= CMIN) ? (cap_cnt - CMIN) : '0;
        s1_oor     <= (cap_cnt < CMIN) || (cap_cnt > CMAX);
      end

      dist_valid <= s1_valid;
      if (s1_valid) begin
        distance     <= WIDTH'(clamped);
        out_of_range <= s1_oor;
        locked       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fm_demod_counter.sv
// Bench for fm_demod_counter: directed phases aligned to gate windows, then a
// random stream, all checked against a window-level crossing-count model.
module tb_fm_demod_counter;

  localparam int W     = 100;
  localparam int CMIN  = 5;
  localparam int CMAX  = 25;
  localparam int HI    = 128 + 16;
  localparam int LO    = 128 - 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  sample = '0;
  logic [15:0] freq_count, freq_count2;
  logic [12:0] distance, distance2;
  logic        dist_valid, dist_valid2;
  logic        out_of_range, out_of_range2;
  logic        locked, locked2;

  always #5 clk = ~clk;

  fm_demod_counter #(
    .WINDOW_CYCLES(W), .CNT_MIN(CMIN), .CNT_MAX(CMAX),
    .DIST_NUM(3), .DIST_SHIFT(1), .MAX_DIST(2000)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample(sample),
    .freq_count(freq_count), .distance(distance), .dist_valid(dist_valid),
    .out_of_range(out_of_range), .locked(locked)
  );

  fm_demod_counter #(
    .WINDOW_CYCLES(W), .CNT_MIN(CMIN), .CNT_MAX(CMAX),
    .DIST_NUM(3), .DIST_SHIFT(1), .MAX_DIST(40)
  ) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .sample(sample),
    .freq_count(freq_count2), .distance(distance2), .dist_valid(dist_valid2),
    .out_of_range(out_of_range2), .locked(locked2)
  );

  typedef struct { int cyc; int cnt; } ev_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   seen_cyc = -1;
  int   win_cnt  = 0;
  int   win_len  = 0;
  bit   m_high   = 0;
  bit   m_warm   = 1;
  bit   e_locked = 0;
  ev_t  evq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_dist(input int c, input int maxd);
    int d;
    d = (c < CMIN) ? 0 : c - CMIN;
    d = (d * 3) >> 1;
    if (d > maxd) d = maxd;
    if (d > 8191) d = 8191;
    return d;
  endfunction

  // One clock: drive, then update the model and compare outputs 1 ns after the edge
  task automatic tick(input logic r, input logic en, input logic [7:0] s);
    ev_t e;
    bit  exp_v;
    reset = r; enable = en; sample = s;
    @(posedge clk); #1;
    cyc++;
    if (r) begin
      evq.delete();
      win_cnt = 0; win_len = 0; m_high = 0; m_warm = 1; e_locked = 0; seen_cyc = -1;
    end else if (en) begin
      if (!m_high && s >= HI) begin
        m_high = 1;
        win_cnt++;
      end else if (m_high && s <= LO) begin
        m_high = 0;
      end
      win_len++;
      if (win_len == W) begin
        if (!m_warm) evq.push_back('{cyc + 2, win_cnt});
        m_warm = 0; win_cnt = 0; win_len = 0;
      end
    end
    exp_v = (evq.size() > 0) && (evq[0].cyc == cyc);
    chk("dist_valid", 32'(dist_valid), 32'(exp_v));
    if (exp_v) begin
      e = evq.pop_front();
      seen_cyc = cyc;
      e_locked = 1;
      chk("freq_count", 32'(freq_count), e.cnt);
      chk("distance", 32'(distance), exp_dist(e.cnt, 2000));
      chk("out_of_range", 32'(out_of_range), 32'((e.cnt < CMIN) || (e.cnt > CMAX)));
      chk("distance_clamp40", 32'(distance2), exp_dist(e.cnt, 40));
    end
    chk("locked", 32'(locked), 32'(e_locked));
  endtask

  function automatic logic [7:0] gen(input int mode, input int j);
    case (mode)
      0: return (j % 10 < 5) ? 8'd0 : 8'd255;
      1: return 8'(120 + j % 17);
      2: return (j % 2 == 1) ? 8'd255 : 8'd0;
      3: return (j == W - 1) ? 8'd255 : 8'd0;
      4: return (j == 40) ? 8'd255 : 8'd0;
      5: return (j == 0 || j == W - 1) ? 8'd255 : 8'd0;
      default: return 8'd128;
    endcase
  endfunction

  // One full window of W enabled samples, optional enable gap, then 2 idle clocks
  task automatic phase(input int mode, input int gap_at, input int gap_len);
    for (int j = 0; j < W; j++) begin
      if (j == gap_at) begin
        for (int g = 0; g < gap_len; g++) tick(1'b0, 1'b0, 8'($urandom_range(0, 255)));
      end
      tick(1'b0, 1'b1, gen(mode, j));
    end
    tick(1'b0, 1'b0, 8'd128);
    tick(1'b0, 1'b0, 8'd128);
  endtask

  int start;

  initial begin
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, (i % 2 == 1) ? 8'd255 : 8'd0);
    chk("reset_freq_count", 32'(freq_count), 0);
    chk("reset_distance", 32'(distance), 0);
    chk("reset_dist_valid", 32'(dist_valid), 0);
    chk("reset_out_of_range", 32'(out_of_range), 0);
    chk("reset_locked", 32'(locked), 0);

    phase(0, -1, 0);
    chk("warmup_locked", 32'(locked), 0);
    chk("warmup_freq_count", 32'(freq_count), 0);

    start = cyc;
    phase(0, -1, 0);
    chk("nominal_freq", 32'(freq_count), 10);
    chk("nominal_dist", 32'(distance), 7);
    chk("nominal_oor", 32'(out_of_range), 0);
    chk("nominal_locked", 32'(locked), 1);
    chk("nominal_latency", 32'(seen_cyc - start), W + 2);

    phase(1, -1, 0);
    chk("hyst_freq", 32'(freq_count), 0);
    chk("hyst_dist", 32'(distance), 0);
    chk("hyst_oor", 32'(out_of_range), 1);

    phase(2, -1, 0);
    chk("clamp_freq", 32'(freq_count), 50);
    chk("clamp_dist", 32'(distance), 67);
    chk("clamp_oor", 32'(out_of_range), 1);
    chk("clamp_dist_max40", 32'(distance2), 40);

    phase(3, -1, 0);
    chk("boundary_last_cycle", 32'(freq_count), 1);
    phase(4, -1, 0);
    chk("boundary_mid", 32'(freq_count), 1);
    phase(5, -1, 0);
    chk("boundary_first_and_last", 32'(freq_count), 2);

    start = cyc;
    phase(0, 50, 37);
    chk("gap_freq", 32'(freq_count), 10);
    chk("gap_latency", 32'(seen_cyc - start), W + 2 + 37);

    for (int j = 0; j < 50; j++) tick(1'b0, 1'b1, gen(0, j));
    tick(1'b1, 1'b1, 8'd255);
    start = cyc;
    phase(0, -1, 0);
    chk("reset_mid_warmup_no_valid", 32'(seen_cyc), 32'(-1));
    chk("reset_mid_locked", 32'(locked), 0);
    phase(0, -1, 0);
    chk("reset_mid_latency", 32'(seen_cyc - start), 2 * (W + 2));
    chk("reset_mid_freq", 32'(freq_count), 10);

    for (int i = 0; i < 900; i++)
      tick(1'b0, 1'($urandom_range(0, 99) < 85), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'd128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
